// File: rtl/instruction_decode_queue.sv
// instruction_decode_queue: DEPTH-entry fetch FIFO feeding a registered
// RV32I -> microcode-address decode stage with valid/ready handshakes.
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN (flag unrecognised opcodes
// on out_illegal instead of silently decoding them to nop).
module instruction_decode_queue #(
    parameter int DEPTH   = 4,
    parameter int XLEN    = 32,
    parameter int UADDR_W = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clk_enable,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instruction,
    input  logic [XLEN-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [UADDR_W-1:0]         out_uaddr,
    output logic [24:0]                out_data,
    output logic [XLEN-1:0]            out_pc,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Opcode/funct3 to 6-bit microcode address; unknown opcodes map to nop.
    function automatic logic [5:0] decode_uaddr(input logic [31:0] ins);
        logic [2:0] f3;
        f3 = ins[14:12];
        case (ins[6:0])
            7'b0110111: decode_uaddr = 6'h01;
            7'b0010111: decode_uaddr = 6'h02;
            7'b1101111: decode_uaddr = 6'h03;
            7'b1100111: decode_uaddr = 6'h04;
            7'b1100011: decode_uaddr = {3'b001, f3};
            7'b0000011: decode_uaddr = {3'b010, f3};
            7'b0100011: decode_uaddr = {3'b011, f3};
            // Only SRAI (f3=101) uses bit 30 as an opcode modifier.
            7'b0010011: decode_uaddr = {1'b1, ins[30] & (f3 == 3'b101), 1'b0, f3};
            7'b0110011: decode_uaddr = {1'b1, ins[30], 1'b1, f3};
            default:    decode_uaddr = 6'h00;
        endcase
    endfunction

`ifdef DECODE_ILLEGAL_TRAP_EN
    // True for every opcode the decoder recognises.
    function automatic logic decode_known(input logic [6:0] op);
        case (op)
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
            7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
            7'b0110011: decode_known = 1'b1;
            default:    decode_known = 1'b0;
        endcase
    endfunction
`endif

    logic [31:0]        instr_mem_q [DEPTH];
    logic [31:0]        instr_mem_d [DEPTH];
    logic [XLEN-1:0]    pc_mem_q    [DEPTH];
    logic [XLEN-1:0]    pc_mem_d    [DEPTH];

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               out_valid_q, out_valid_d;
    logic [UADDR_W-1:0] out_uaddr_q, out_uaddr_d;
    logic [24:0]        out_data_q, out_data_d;
    logic [XLEN-1:0]    out_pc_q, out_pc_d;

    logic               push, pop;
    logic [31:0]        head_instr;

    assign in_ready   = (count_q < CNT_W'(DEPTH));
    assign head_instr = instr_mem_q[rd_ptr_q];

    // Handshake qualification; flush and stall gating happen in next-state logic.
    always_comb begin
        push = clk_enable & in_valid & in_ready;
        pop  = clk_enable & (count_q != '0) & (~out_valid_q | out_ready);
    end

    // FIFO pointers, occupancy and output stage next state.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_uaddr_d = out_uaddr_q;
        out_data_d  = out_data_q;
        out_pc_d    = out_pc_q;
        if (clk_enable) begin
            if (flush) begin
                // Output fields keep their last value; only valid is cleared.
                wr_ptr_d    = '0;
                rd_ptr_d    = '0;
                count_d     = '0;
                out_valid_d = 1'b0;
            end else begin
                if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
                if (pop) begin
                    rd_ptr_d    = rd_ptr_q + PTR_W'(1);
                    out_valid_d = 1'b1;
                    out_uaddr_d = UADDR_W'(decode_uaddr(head_instr));
                    out_data_d  = head_instr[31:7];
                    out_pc_d    = pc_mem_q[rd_ptr_q];
                end else if (out_valid_q & out_ready) begin
                    out_valid_d = 1'b0;
                end
                case ({push, pop})
                    2'b10:   count_d = count_q + CNT_W'(1);
                    2'b01:   count_d = count_q - CNT_W'(1);
                    default: count_d = count_q;
                endcase
            end
        end
    end

    // Storage write on an accepted push that is not overridden by flush.
    always_comb begin
        instr_mem_d = instr_mem_q;
        pc_mem_d    = pc_mem_q;
        if (push & ~flush) begin
            instr_mem_d[wr_ptr_q] = in_instruction;
            pc_mem_d[wr_ptr_q]    = in_pc;
        end
    end

    // FIFO payload storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        instr_mem_q <= instr_mem_d;
        pc_mem_q    <= pc_mem_d;
    end

    // Control and output-stage registers; reset beats clk_enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_uaddr_q <= '0;
            out_data_q  <= '0;
            out_pc_q    <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_uaddr_q <= out_uaddr_d;
            out_data_q  <= out_data_d;
            out_pc_q    <= out_pc_d;
        end
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic out_illegal_q, out_illegal_d;

    // Illegal flag travels with the decoded entry through the output stage.
    always_comb begin
        out_illegal_d = out_illegal_q;
        if (clk_enable & ~flush & pop) out_illegal_d = ~decode_known(head_instr[6:0]);
    end

    // Illegal flag register.
    always_ff @(posedge clk) begin
        if (rst) out_illegal_q <= 1'b0;
        else     out_illegal_q <= out_illegal_d;
    end

    assign out_illegal = out_illegal_q;
`else
    assign out_illegal = 1'b0;
`endif

    assign out_valid = out_valid_q;
    assign out_uaddr = out_uaddr_q;
    assign out_data  = out_data_q;
    assign out_pc    = out_pc_q;
    assign count     = count_q;

endmodule

// File: tb/tb_instruction_decode_queue.sv
// Bench for instruction_decode_queue: directed scenarios plus random traffic,
// checked every cycle against a queue-based reference model.
module tb_instruction_decode_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, clk_enable, flush, in_valid, out_ready;
    logic        in_ready, out_valid, out_illegal;
    logic [31:0] in_instruction, in_pc, out_pc;
    logic [5:0]  out_uaddr;
    logic [24:0] out_data;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    instruction_decode_queue #(.DEPTH(DEPTH), .XLEN(32), .UADDR_W(6)) dut (
        .clk(clk), .rst(rst), .clk_enable(clk_enable), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instruction(in_instruction),
        .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_uaddr(out_uaddr), .out_data(out_data), .out_pc(out_pc),
        .out_illegal(out_illegal), .count(count)
    );

    always #5 clk = ~clk;

    // Reference model state
    typedef struct { logic [31:0] ins; logic [31:0] pc; } ent_t;
    ent_t        mq[$];
    logic        m_ov;
    logic [5:0]  m_ua;
    logic [24:0] m_data;
    logic [31:0] m_pc;
    logic        m_ill;

    function automatic logic [5:0] ref_uaddr(input logic [31:0] i);
        int f3;
        f3 = int'(i[14:12]);
        case (i[6:0])
            7'h37: return 6'd1;
            7'h17: return 6'd2;
            7'h6F: return 6'd3;
            7'h67: return 6'd4;
            7'h63: return 6'(8 + f3);
            7'h03: return 6'(16 + f3);
            7'h23: return 6'(24 + f3);
            7'h13: return 6'(32 + ((i[30] && f3 == 5) ? 16 : 0) + f3);
            7'h33: return 6'(40 + (i[30] ? 16 : 0) + f3);
            default: return 6'd0;
        endcase
    endfunction

    function automatic logic ref_illegal(input logic [31:0] i);
`ifdef DECODE_ILLEGAL_TRAP_EN
        case (i[6:0])
            7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33: return 1'b0;
            default: return 1'b1;
        endcase
`else
        return 1'b0 & i[0];
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model with the current inputs, clock the DUT, compare.
    task automatic step();
        ent_t e;
        bit   do_push, do_pop;
        if (rst) begin
            mq.delete();
            m_ov = 0; m_ua = 0; m_data = 0; m_pc = 0; m_ill = 0;
        end else if (clk_enable) begin
            if (flush) begin
                mq.delete();
                m_ov = 0;
            end else begin
                do_push = in_valid && (mq.size() < DEPTH);
                do_pop  = (mq.size() > 0) && (!m_ov || out_ready);
                if (do_pop) begin
                    e      = mq.pop_front();
                    m_ov   = 1;
                    m_ua   = ref_uaddr(e.ins);
                    m_data = e.ins[31:7];
                    m_pc   = e.pc;
                    m_ill  = ref_illegal(e.ins);
                end else if (m_ov && out_ready) begin
                    m_ov = 0;
                end
                if (do_push) begin
                    e.ins = in_instruction;
                    e.pc  = in_pc;
                    mq.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
        chk("count",       64'(count),       64'(mq.size()));
        chk("in_ready",    64'(in_ready),    64'(mq.size() < DEPTH));
        chk("out_valid",   64'(out_valid),   64'(m_ov));
        chk("out_uaddr",   64'(out_uaddr),   64'(m_ua));
        chk("out_data",    64'(out_data),    64'(m_data));
        chk("out_pc",      64'(out_pc),      64'(m_pc));
        chk("out_illegal", 64'(out_illegal), 64'(m_ill));
    endtask

    task automatic drive(input logic v, input logic [31:0] ins);
        in_valid       = v;
        in_instruction = ins;
        in_pc          = $urandom;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  ops [10];
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h00};
        r = $urandom;
        r[6:0] = ops[$urandom_range(0, 9)];
        if ($urandom_range(0, 9) == 0) r[6:0] = 7'($urandom);
        return r;
    endfunction

    logic [31:0] stream [4];

    initial begin
        rst = 1; clk_enable = 1; flush = 0; out_ready = 1;
        drive(0, 32'h0);
        step(); step();
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_ovalid", 64'(out_valid), 64'd0);
        rst = 0;

        // LUI latency: pushed in cycle 0, visible in cycle 2
        drive(1, 32'h000280B7);
        step();
        chk("lui_not_yet", 64'(out_valid), 64'd0);
        drive(0, 32'h0);
        step();
        chk("lui_valid", 64'(out_valid), 64'd1);
        chk("lui_uaddr", 64'(out_uaddr), 64'h01);
        chk("lui_data",  64'(out_data),  64'h0000501);

        // Back-to-back R-type and shift-immediate stream
        stream = '{32'h002081B3, 32'h402081B3, 32'h4050D093, 32'h0050D093};
        for (int i = 0; i < 4; i++) begin drive(1, stream[i]); step(); end
        drive(0, 32'h0);
        repeat (3) step();

        // Back-pressure: out_ready low, push DEPTH+1 (plus one held in output)
        out_ready = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin drive(1, rand_instr()); step(); end
        chk("full_in_ready", 64'(in_ready), 64'd0);
        drive(0, 32'h0);
        repeat (2) step();
        out_ready = 1;
        repeat (DEPTH + 3) step();

        // Flush with a simultaneous push
        out_ready = 0;
        for (int i = 0; i < 4; i++) begin drive(1, rand_instr()); step(); end
        chk("pre_flush_count", 64'(count), 64'd3);
        flush = 1;
        drive(1, 32'h00000013);
        step();
        flush = 0;
        drive(0, 32'h0);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_ovalid", 64'(out_valid), 64'd0);
        out_ready = 1;
        repeat (3) step();

        // Global stall mid-stream
        for (int i = 0; i < 2; i++) begin drive(1, rand_instr()); step(); end
        clk_enable = 0;
        repeat (3) begin drive(1, rand_instr()); step(); end
        clk_enable = 1;
        drive(0, 32'h0);
        repeat (4) step();

        // All-ones word decodes to nop (illegal only with the trap build)
        drive(1, 32'hFFFFFFFF);
        step();
        drive(0, 32'h0);
        step();
        chk("ones_uaddr", 64'(out_uaddr), 64'h00);
`ifdef DECODE_ILLEGAL_TRAP_EN
        chk("ones_illegal", 64'(out_illegal), 64'd1);
`else
        chk("ones_illegal", 64'(out_illegal), 64'd0);
`endif
        step();

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            clk_enable = ($urandom_range(0, 7) != 0);
            flush      = ($urandom_range(0, 40) == 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            drive(logic'($urandom_range(0, 2) != 0), rand_instr());
            step();
        end
        clk_enable = 1; flush = 0; out_ready = 1;
        drive(0, 32'h0);
        repeat (DEPTH + 3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
